// File: rtl/vend_sequencer.sv
// Vending transaction controller: accumulates coin credit, checks selections
// against a fixed price table, runs the dispense handshake and returns change.
module vend_sequencer #(
    parameter int CREDIT_W   = 8,
    parameter int MAX_CREDIT = 200,
    parameter int PRICE0     = 3,
    parameter int PRICE1     = 4,
    parameter int PRICE2     = 5,
    parameter int PRICE3     = 7,
    parameter int TIMEOUT    = 1000
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                coin_valid,
    input  logic [1:0]          coin,
    input  logic                sel_valid,
    input  logic [1:0]          sel,
    input  logic                cancel,
    output logic                disp_req,
    output logic [1:0]          disp_id,
    input  logic                disp_ack,
    output logic                chg_req,
    input  logic                chg_ack,
    output logic [CREDIT_W-1:0] credit,
    output logic                coin_reject,
    output logic                sel_short,
    output logic                vend_done,
    output logic                busy
);
    typedef enum logic [1:0] {S_IDLE, S_CREDIT, S_VEND, S_CHANGE} state_t;
    typedef logic [CREDIT_W:0] wide_t;

    localparam int TMR_W = $clog2(TIMEOUT);
    localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(TIMEOUT - 1);
    localparam int PRICES [4] = '{PRICE0, PRICE1, PRICE2, PRICE3};

    state_t              state_q;
    logic [CREDIT_W-1:0] credit_q;
    logic [TMR_W-1:0]    idle_cnt_q;
    logic                disp_req_q;
    logic [1:0]          disp_id_q;
    logic                chg_req_q;
    logic                coin_reject_q;
    logic                sel_short_q;
    logic                vend_done_q;
    logic                busy_q;

    wide_t price_tbl [4];
    wide_t coin_val_d;
    wide_t coin_sum_d;
    wide_t sel_price_d;
    logic  coin_evt_d;
    logic  cancel_hit_d;
    logic  coin_take_d;
    logic  sel_fit_d;

    for (genvar gi = 0; gi < 4; gi++) begin : g_price
        assign price_tbl[gi] = wide_t'(PRICES[gi]);
    end

    // All credit arithmetic is one bit wider than the register so that the
    // ceiling and price comparisons can never be fooled by wrap-around.
    always_comb begin
        coin_val_d = '0;
        case (coin)
            2'd1:    coin_val_d = wide_t'(1);
            2'd2:    coin_val_d = wide_t'(2);
            2'd3:    coin_val_d = wide_t'(5);
            default: coin_val_d = '0;
        endcase
        coin_sum_d   = wide_t'(credit_q) + coin_val_d;
        sel_price_d  = price_tbl[sel];
        sel_fit_d    = wide_t'(credit_q) >= sel_price_d;
        coin_evt_d   = coin_valid && (coin != 2'd0);
        cancel_hit_d = cancel && (state_q == S_CREDIT);
        coin_take_d  = coin_evt_d && !cancel_hit_d &&
                       ((state_q == S_IDLE) || (state_q == S_CREDIT)) &&
                       (coin_sum_d <= wide_t'(MAX_CREDIT));
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= S_IDLE;
            credit_q      <= '0;
            idle_cnt_q    <= '0;
            disp_req_q    <= 1'b0;
            disp_id_q     <= 2'd0;
            chg_req_q     <= 1'b0;
            coin_reject_q <= 1'b0;
            sel_short_q   <= 1'b0;
            vend_done_q   <= 1'b0;
            busy_q        <= 1'b0;
        end else begin
            coin_reject_q <= coin_evt_d && !coin_take_d;
            sel_short_q   <= 1'b0;
            vend_done_q   <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (coin_take_d) begin
                        credit_q   <= coin_sum_d[CREDIT_W-1:0];
                        idle_cnt_q <= '0;
                        state_q    <= S_CREDIT;
                    end else if (sel_valid && !coin_evt_d) begin
                        sel_short_q <= 1'b1;
                    end
                end
                S_CREDIT: begin
                    if (cancel) begin
                        chg_req_q <= 1'b1;
                        busy_q    <= 1'b1;
                        state_q   <= S_CHANGE;
                    end else if (coin_take_d) begin
                        credit_q   <= coin_sum_d[CREDIT_W-1:0];
                        idle_cnt_q <= '0;
                    end else if (sel_valid) begin
                        // A selection that lost to a coin still counts as activity.
                        idle_cnt_q <= '0;
                        if (!coin_evt_d) begin
                            if (sel_fit_d) begin
                                credit_q   <= credit_q - sel_price_d[CREDIT_W-1:0];
                                disp_id_q  <= sel;
                                disp_req_q <= 1'b1;
                                busy_q     <= 1'b1;
                                state_q    <= S_VEND;
                            end else begin
                                sel_short_q <= 1'b1;
                            end
                        end
                    end else if (idle_cnt_q == TMR_LAST) begin
                        chg_req_q <= 1'b1;
                        busy_q    <= 1'b1;
                        state_q   <= S_CHANGE;
                    end else begin
                        idle_cnt_q <= idle_cnt_q + TMR_W'(1);
                    end
                end
                S_VEND: begin
                    if (disp_ack) begin
                        disp_req_q  <= 1'b0;
                        vend_done_q <= 1'b1;
                        if (credit_q != '0) begin
                            chg_req_q <= 1'b1;
                            state_q   <= S_CHANGE;
                        end else begin
                            busy_q  <= 1'b0;
                            state_q <= S_IDLE;
                        end
                    end
                end
                S_CHANGE: begin
                    if (chg_ack) begin
                        credit_q <= credit_q - CREDIT_W'(1);
                        if (credit_q == CREDIT_W'(1)) begin
                            chg_req_q <= 1'b0;
                            busy_q    <= 1'b0;
                            state_q   <= S_IDLE;
                        end
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign disp_req    = disp_req_q;
    assign disp_id     = disp_id_q;
    assign chg_req     = chg_req_q;
    assign credit      = credit_q;
    assign coin_reject = coin_reject_q;
    assign sel_short   = sel_short_q;
    assign vend_done   = vend_done_q;
    assign busy        = busy_q;

endmodule

// File: tb/tb_vend_sequencer.sv
// Bench for vend_sequencer: directed scenarios with literal expectations, then
// randomized traffic checked every cycle against a transaction-level model.
module tb_vend_sequencer;
    localparam int CW   = 8;
    localparam int MAXC = 200;
    localparam int TO   = 16;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          coin_valid = 1'b0;
    logic [1:0]    coin = 2'd0;
    logic          sel_valid = 1'b0;
    logic [1:0]    sel = 2'd0;
    logic          cancel = 1'b0;
    logic          disp_ack = 1'b0;
    logic          chg_ack = 1'b0;
    logic          disp_req;
    logic [1:0]    disp_id;
    logic          chg_req;
    logic [CW-1:0] credit;
    logic          coin_reject;
    logic          sel_short;
    logic          vend_done;
    logic          busy;

    vend_sequencer #(
        .CREDIT_W(CW), .MAX_CREDIT(MAXC),
        .PRICE0(3), .PRICE1(4), .PRICE2(5), .PRICE3(7), .TIMEOUT(TO)
    ) dut (
        .clk(clk), .rst(rst),
        .coin_valid(coin_valid), .coin(coin),
        .sel_valid(sel_valid), .sel(sel), .cancel(cancel),
        .disp_req(disp_req), .disp_id(disp_id), .disp_ack(disp_ack),
        .chg_req(chg_req), .chg_ack(chg_ack), .credit(credit),
        .coin_reject(coin_reject), .sel_short(sel_short),
        .vend_done(vend_done), .busy(busy)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;
    bit check_en = 1'b0;

    // ---------------- behavioural model ----------------
    localparam int M_IDLE = 0, M_CREDIT = 1, M_VEND = 2, M_CHANGE = 3;
    int         m_mode, m_credit, m_idle, m_units;
    logic [1:0] m_did;
    bit         m_dreq, m_chg, m_rej, m_short, m_done;
    bit         m_seen, m_took, m_cancel;

    function automatic int price(input logic [1:0] s);
        case (s)
            2'd0:    return 3;
            2'd1:    return 4;
            2'd2:    return 5;
            default: return 7;
        endcase
    endfunction

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_mode = M_IDLE; m_credit = 0; m_idle = 0; m_did = 2'd0;
            m_dreq = 0; m_chg = 0; m_rej = 0; m_short = 0; m_done = 0;
        end else begin
            m_units  = (coin == 2'd3) ? 5 : int'(coin);
            m_seen   = coin_valid && (m_units > 0);
            m_cancel = cancel && (m_mode == M_CREDIT);
            m_took   = m_seen && !m_cancel && (m_mode == M_IDLE || m_mode == M_CREDIT)
                       && (m_credit + m_units <= MAXC);
            m_rej    = m_seen && !m_took;
            m_short  = 0;
            m_done   = 0;
            case (m_mode)
                M_IDLE: begin
                    if (m_took) begin
                        m_credit += m_units; m_idle = 0; m_mode = M_CREDIT;
                    end else if (sel_valid && !m_seen) m_short = 1;
                end
                M_CREDIT: begin
                    if (m_cancel) begin
                        m_mode = M_CHANGE; m_chg = 1;
                    end else if (m_took) begin
                        m_credit += m_units; m_idle = 0;
                    end else if (sel_valid) begin
                        m_idle = 0;
                        if (!m_seen) begin
                            if (m_credit >= price(sel)) begin
                                m_credit -= price(sel); m_did = sel; m_dreq = 1; m_mode = M_VEND;
                            end else m_short = 1;
                        end
                    end else begin
                        m_idle++;
                        if (m_idle == TO) begin m_mode = M_CHANGE; m_chg = 1; end
                    end
                end
                M_VEND: begin
                    if (disp_ack) begin
                        m_dreq = 0; m_done = 1;
                        if (m_credit > 0) begin m_mode = M_CHANGE; m_chg = 1; end
                        else m_mode = M_IDLE;
                    end
                end
                default: begin
                    if (chg_ack) begin
                        m_credit--;
                        if (m_credit == 0) begin m_chg = 0; m_mode = M_IDLE; end
                    end
                end
            endcase
        end
    end

    // Cycle-by-cycle comparison against the model, away from the active edge.
    always @(negedge clk) begin
        if (check_en) begin
            n_cmp++;
            if ({disp_req, disp_id, chg_req, credit, coin_reject, sel_short, vend_done, busy} !==
                {m_dreq, m_did, m_chg, CW'(m_credit), m_rej, m_short, m_done,
                 (m_mode == M_VEND || m_mode == M_CHANGE)}) begin
                n_bad++;
                $display("FAIL cycle t=%0t: got req=%b id=%0d chg=%b cr=%0d rej=%b sh=%b dn=%b bz=%b exp req=%b id=%0d chg=%b cr=%0d rej=%b sh=%b dn=%b bz=%b",
                         $time, disp_req, disp_id, chg_req, credit, coin_reject, sel_short, vend_done, busy,
                         m_dreq, m_did, m_chg, m_credit, m_rej, m_short, m_done,
                         (m_mode == M_VEND || m_mode == M_CHANGE));
            end
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", nm, got, exp);
        end else begin
            $display("txn %s: %0d ok", nm, got);
        end
    endtask

    task automatic step(input bit cv, input logic [1:0] c, input bit sv, input logic [1:0] s,
                        input bit cn, input bit da, input bit ca);
        coin_valid = cv; coin = c; sel_valid = sv; sel = s;
        cancel = cn; disp_ack = da; chg_ack = ca;
        @(posedge clk);
        #1;
        coin_valid = 0; coin = 2'd0; sel_valid = 0; sel = 2'd0;
        cancel = 0; disp_ack = 0; chg_ack = 0;
    endtask

    task automatic coin_in(input logic [1:0] c);
        step(1, c, 0, 2'd0, 0, 0, 0);
    endtask

    task automatic idle_cycle();
        step(0, 2'd0, 0, 2'd0, 0, 0, 0);
    endtask

    task automatic drain(output int n);
        n = 0;
        while (chg_req && n < 400) begin
            step(0, 2'd0, 0, 2'd0, 0, 0, 1);
            n++;
        end
    endtask

    task automatic async_reset_check(input string tag);
        #2 rst = 1'b1;
        #1;
        chk({tag, "_disp_req"}, 32'(disp_req), 0);
        chk({tag, "_chg_req"},  32'(chg_req), 0);
        chk({tag, "_credit"},   32'(credit), 0);
        chk({tag, "_busy"},     32'(busy), 0);
        @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    int n;

    initial begin
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        check_en = 1'b1;
        #1;
        chk("reset_credit", 32'(credit), 0);
        chk("reset_disp_req", 32'(disp_req), 0);
        chk("reset_busy", 32'(busy), 0);

        // 2u+2u, select product 1 at exact price
        coin_in(2'd2); coin_in(2'd2);
        chk("s1_credit", 32'(credit), 4);
        step(0, 2'd0, 1, 2'd1, 0, 0, 0);
        chk("s1_disp_req", 32'(disp_req), 1);
        chk("s1_disp_id", 32'(disp_id), 1);
        chk("s1_credit_after_sel", 32'(credit), 0);
        step(0, 2'd0, 0, 2'd0, 0, 1, 0);
        chk("s1_vend_done", 32'(vend_done), 1);
        chk("s1_no_chg_req", 32'(chg_req), 0);
        chk("s1_idle_busy", 32'(busy), 0);

        // 5u+2u, select product 0, 4 units change
        coin_in(2'd3); coin_in(2'd2);
        step(0, 2'd0, 1, 2'd0, 0, 0, 0);
        chk("s2_credit_after_sel", 32'(credit), 4);
        step(0, 2'd0, 0, 2'd0, 0, 1, 0);
        chk("s2_chg_req", 32'(chg_req), 1);
        drain(n);
        chk("s2_change_acks", 32'(n), 4);
        chk("s2_credit_end", 32'(credit), 0);

        // 1u, short select, then cancel refund
        coin_in(2'd1);
        step(0, 2'd0, 1, 2'd3, 0, 0, 0);
        chk("s3_sel_short", 32'(sel_short), 1);
        chk("s3_credit", 32'(credit), 1);
        step(0, 2'd0, 0, 2'd0, 1, 0, 0);
        chk("s3_cancel_chg_req", 32'(chg_req), 1);
        drain(n);
        chk("s3_refund_acks", 32'(n), 1);

        // credit ceiling
        repeat (39) coin_in(2'd3);
        coin_in(2'd2); coin_in(2'd1);
        chk("s4_credit_198", 32'(credit), 198);
        coin_in(2'd3);
        chk("s4_coin_reject", 32'(coin_reject), 1);
        chk("s4_credit_kept", 32'(credit), 198);
        step(1, 2'd1, 0, 2'd0, 1, 0, 0);
        chk("s4_cancel_beats_coin", 32'(coin_reject), 1);
        chk("s4_refund_start", 32'(chg_req), 1);
        drain(n);
        chk("s4_refund_acks", 32'(n), 198);

        // inactivity timeout
        coin_in(2'd2);
        repeat (TO - 1) idle_cycle();
        chk("s5_before_timeout", 32'(chg_req), 0);
        idle_cycle();
        chk("s5_timeout_chg_req", 32'(chg_req), 1);
        drain(n);
        chk("s5_timeout_acks", 32'(n), 2);

        // asynchronous reset mid-VEND and mid-CHANGE
        coin_in(2'd3); coin_in(2'd3);
        step(0, 2'd0, 1, 2'd2, 0, 0, 0);
        async_reset_check("s6_vend");
        coin_in(2'd3);
        step(0, 2'd0, 0, 2'd0, 1, 0, 0);
        async_reset_check("s6_change");

        // randomized traffic with periodic quiet stretches
        for (int i = 0; i < 2500; i++) begin
            if ((i % 300) >= 270) begin
                step(0, 2'd0, 0, 2'd0, 0, ($urandom_range(0, 99) < 30), ($urandom_range(0, 99) < 50));
            end else begin
                step(($urandom_range(0, 99) < 25), 2'($urandom_range(0, 3)),
                     ($urandom_range(0, 99) < 20), 2'($urandom_range(0, 3)),
                     ($urandom_range(0, 99) < 3),
                     ($urandom_range(0, 99) < 30), ($urandom_range(0, 99) < 50));
            end
        end

        @(negedge clk);
        #1;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
